// File: rtl/icape2_pkg.sv
// Shared constants and types for the ICAPE2 responder: special words, register map,
// CMD codes, type-1 header field positions, opcode and state enums.
package icape2_pkg;

    localparam logic [31:0] SYNC_WORD  = 32'hAA995566;
    localparam logic [31:0] NOOP_WORD  = 32'h20000000;
    localparam logic [31:0] DUMMY_WORD = 32'hFFFFFFFF;

    localparam logic [4:0] REG_CMD    = 5'h04;
    localparam logic [4:0] REG_IDCODE = 5'h0C;
    localparam logic [4:0] REG_WBSTAR = 5'h10;

    localparam logic [4:0] CMD_DESYNC = 5'h0D;
    localparam logic [4:0] CMD_IPROG  = 5'h0F;

    localparam int HDR_TYPE_HI = 31;
    localparam int HDR_TYPE_LO = 29;
    localparam int HDR_OP_HI   = 28;
    localparam int HDR_OP_LO   = 27;
    localparam int HDR_ADDR_HI = 17;
    localparam int HDR_ADDR_LO = 13;
    localparam int HDR_WC_HI   = 10;
    localparam int HDR_WC_LO   = 0;

    localparam logic [2:0] HDR_TYPE1 = 3'b001;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_DESYNC,
        ST_HDR,
        ST_WDATA,
        ST_RWAIT,
        ST_RLAT,
        ST_RDATA
    } state_e;

    // Padding words that may appear between packets and carry no meaning.
    function automatic logic is_filler(input logic [31:0] word);
        return (word == NOOP_WORD) || (word == DUMMY_WORD);
    endfunction

endpackage

// File: rtl/icape2_bitswap.sv
// Reverses bit order inside each byte of a 32-bit word (ICAPE2 physical pin order).
module icape2_bitswap (
    input  logic [31:0] word,
    output logic [31:0] swapped
);

    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
        assign swapped[gi] = word[(gi / 8) * 8 + 7 - (gi % 8)];
    end

endmodule

// File: rtl/icape2_responder.sv
// Cycle-level ICAPE2 responder: sync hunt, type-1 packet decode, 32-entry register file.
// Define ICAPE2_RESP_BITSWAP_EN to present I/O words in physical per-byte bit-reversed order.
module icape2_responder
    import icape2_pkg::*;
#(
    parameter logic [31:0] IDCODE   = 32'h0362D093,
    parameter int          READ_LAT = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_csib,
    input  logic        i_rdwrb,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_synced,
    output logic        o_iprog,
    output logic [31:0] o_wbstar,
    output logic        o_err
);

    logic [31:0] data_in;
    logic [31:0] data_out_reg;
    state_e      state_reg;
    logic [10:0] cnt_reg;
    logic [2:0]  lat_reg;
    logic [4:0]  addr_reg;
    logic        valid_reg;
    logic        synced_reg;
    logic        iprog_reg;
    logic        err_reg;
    logic [31:0] wbstar_reg;
    logic        prev_act_reg;
    logic        prev_rd_reg;
    logic [31:0] cfg_reg [32];

    logic [2:0]  hdr_type;
    op_e         hdr_op;
    logic [4:0]  hdr_addr;
    logic [10:0] hdr_wc;
    logic        accept;
    logic        dir_flip;
    logic        cmd_desync;
    logic        cmd_iprog;
    logic        wr_en;
    logic [31:0] rd_word;

`ifdef ICAPE2_RESP_BITSWAP_EN
    icape2_bitswap u_swap_in (
        .word    (i_data),
        .swapped (data_in)
    );
    icape2_bitswap u_swap_out (
        .word    (data_out_reg),
        .swapped (o_data)
    );
`else
    assign data_in = i_data;
    assign o_data  = data_out_reg;
`endif

    assign hdr_type = data_in[HDR_TYPE_HI:HDR_TYPE_LO];
    assign hdr_op   = op_e'(data_in[HDR_OP_HI:HDR_OP_LO]);
    assign hdr_addr = data_in[HDR_ADDR_HI:HDR_ADDR_LO];
    assign hdr_wc   = data_in[HDR_WC_HI:HDR_WC_LO];

    assign accept = !i_csib;
    // A direction change only counts if CS stayed low across both cycles.
    assign dir_flip   = accept && prev_act_reg && (i_rdwrb != prev_rd_reg)
                        && (state_reg != ST_DESYNC);
    assign cmd_desync = (addr_reg == REG_CMD) && (data_in[4:0] == CMD_DESYNC);
    assign cmd_iprog  = (addr_reg == REG_CMD) && (data_in[4:0] == CMD_IPROG);
    assign wr_en      = accept && !i_rdwrb && (state_reg == ST_WDATA)
                        && (addr_reg != REG_IDCODE);
    assign rd_word    = (addr_reg == REG_IDCODE) ? IDCODE : cfg_reg[addr_reg];

    for (genvar gi = 0; gi < 32; gi++) begin : g_cfg
        logic [31:0] entry_reg;
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                entry_reg <= '0;
            end else if (wr_en && (addr_reg == 5'(gi))) begin
                entry_reg <= data_in;
            end
        end
        assign cfg_reg[gi] = entry_reg;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= ST_DESYNC;
            cnt_reg      <= '0;
            lat_reg      <= '0;
            addr_reg     <= '0;
            data_out_reg <= DUMMY_WORD;
            valid_reg    <= 1'b0;
            synced_reg   <= 1'b0;
            iprog_reg    <= 1'b0;
            err_reg      <= 1'b0;
            wbstar_reg   <= '0;
            prev_act_reg <= 1'b0;
            prev_rd_reg  <= 1'b0;
        end else begin
            data_out_reg <= DUMMY_WORD;
            valid_reg    <= 1'b0;
            iprog_reg    <= 1'b0;
            wbstar_reg   <= cfg_reg[REG_WBSTAR];
            prev_act_reg <= accept;
            if (accept) begin
                prev_rd_reg <= i_rdwrb;
                if (dir_flip) begin
                    err_reg <= 1'b1;
                    // A DESYNC command still takes effect even when flagged.
                    if ((state_reg == ST_WDATA) && !i_rdwrb && cmd_desync) begin
                        state_reg  <= ST_DESYNC;
                        synced_reg <= 1'b0;
                    end else begin
                        state_reg <= ST_HDR;
                    end
                end else begin
                    case (state_reg)
                        ST_DESYNC: begin
                            if (!i_rdwrb && (data_in == SYNC_WORD)) begin
                                state_reg  <= ST_HDR;
                                synced_reg <= 1'b1;
                            end
                        end
                        ST_HDR: begin
                            if (i_rdwrb) begin
                                err_reg <= 1'b1;
                            end else if (!is_filler(data_in)) begin
                                if ((hdr_type != HDR_TYPE1) || (hdr_op == OP_RSVD)) begin
                                    err_reg <= 1'b1;
                                end else if (hdr_wc != 11'd0) begin
                                    addr_reg <= hdr_addr;
                                    cnt_reg  <= hdr_wc;
                                    if (hdr_op == OP_WRITE) begin
                                        state_reg <= ST_WDATA;
                                    end else if (hdr_op == OP_READ) begin
                                        state_reg <= ST_RWAIT;
                                    end
                                end
                            end
                        end
                        ST_WDATA: begin
                            if (i_rdwrb) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_HDR;
                            end else begin
                                cnt_reg <= cnt_reg - 11'd1;
                                if (cmd_desync || cmd_iprog) begin
                                    state_reg  <= ST_DESYNC;
                                    synced_reg <= 1'b0;
                                    iprog_reg  <= cmd_iprog;
                                end else if (cnt_reg == 11'd1) begin
                                    state_reg <= ST_HDR;
                                end
                            end
                        end
                        ST_RWAIT: begin
                            if (i_rdwrb) begin
                                lat_reg   <= 3'd1;
                                state_reg <= (READ_LAT == 1) ? ST_RDATA : ST_RLAT;
                            end else if (!is_filler(data_in)) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_HDR;
                            end
                        end
                        ST_RLAT: begin
                            if (!i_rdwrb) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_HDR;
                            end else begin
                                lat_reg <= lat_reg + 3'd1;
                                if ((lat_reg + 3'd1) == 3'(READ_LAT)) begin
                                    state_reg <= ST_RDATA;
                                end
                            end
                        end
                        ST_RDATA: begin
                            if (!i_rdwrb) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_HDR;
                            end else begin
                                data_out_reg <= rd_word;
                                valid_reg    <= 1'b1;
                                cnt_reg      <= cnt_reg - 11'd1;
                                if (cnt_reg == 11'd1) begin
                                    state_reg <= ST_HDR;
                                end
                            end
                        end
                        default: state_reg <= ST_DESYNC;
                    endcase
                end
            end
        end
    end

    assign o_valid  = valid_reg;
    assign o_synced = synced_reg;
    assign o_iprog  = iprog_reg;
    assign o_wbstar = wbstar_reg;
    assign o_err    = err_reg;

endmodule

// File: tb/tb_icape2_responder.sv
// Randomized scoreboard bench for icape2_responder against a transaction-level register model.
module tb_icape2_responder;

    localparam logic [31:0] IDCODE   = 32'h0362D093;
    localparam int          READ_LAT = 3;
    localparam logic [31:0] SYNC     = 32'hAA995566;
    localparam logic [31:0] NOOP     = 32'h20000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csib = 1'b1;
    logic        rdwrb = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        valid;
    logic        synced;
    logic        iprog;
    logic [31:0] wbstar;
    logic        err;

    always #5 clk = ~clk;

    icape2_responder #(.IDCODE(IDCODE), .READ_LAT(READ_LAT)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_csib   (csib),
        .i_rdwrb  (rdwrb),
        .i_data   (din),
        .o_data   (dout),
        .o_valid  (valid),
        .o_synced (synced),
        .o_iprog  (iprog),
        .o_wbstar (wbstar),
        .o_err    (err)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_regs [32];
    bit          m_synced = 1'b0;
    bit          m_err = 1'b0;
    int          m_iprog = 0;
    int          iprog_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every presented read word is popped against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_unexpected: got %h, required no read word", dout);
                end else begin
                    chk("rd_data", dout, exp_q.pop_front());
                end
            end
            if (iprog === 1'b1) iprog_seen++;
        end
    end

    function automatic logic [31:0] hdr1(input logic [1:0] op, input logic [4:0] a,
                                         input logic [10:0] wc);
        return {3'b001, op, 9'd0, a, 2'd0, wc};
    endfunction

    task automatic cyc(input logic cs, input logic rw, input logic [31:0] d);
        csib  = cs;
        rdwrb = rw;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        csib = 1'b1;
        rst  = 1'b1;
        #2;
        chk("rst_data", dout, 32'hFFFFFFFF);
        chk("rst_valid", valid, 0);
        chk("rst_synced", synced, 0);
        chk("rst_iprog", iprog, 0);
        chk("rst_wbstar", wbstar, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_synced = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic check_status();
        cyc(1'b1, 1'b0, '0);
        chk("synced", synced, m_synced);
        chk("err", err, m_err);
        chk("wbstar", wbstar, m_regs[16]);
        chk("iprog_cnt", iprog_seen, m_iprog);
        chk("idle_data", dout, 32'hFFFFFFFF);
    endtask

    task automatic do_sync();
        cyc(1'b0, 1'b0, SYNC);
        m_synced = 1'b1;
    endtask

    task automatic do_write(input logic [4:0] a, input int n, input logic [31:0] first);
        logic [31:0] w;
        bit live = m_synced;
        cyc(1'b0, 1'b0, hdr1(2'b10, a, 11'(n)));
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? first : $urandom;
            cyc(1'b0, 1'b0, w);
            if (live) begin
                if (a != 5'h0C) m_regs[a] = w;
                if (a == 5'h04 && w[4:0] == 5'h0D) begin
                    live = 1'b0;
                    m_synced = 1'b0;
                end else if (a == 5'h04 && w[4:0] == 5'h0F) begin
                    live = 1'b0;
                    m_synced = 1'b0;
                    m_iprog++;
                end
            end
        end
    endtask

    task automatic do_read(input logic [4:0] a, input int wc);
        int done = 0;
        cyc(1'b0, 1'b0, hdr1(2'b01, a, 11'(wc)));
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, NOOP);
        if (m_synced) repeat (wc) exp_q.push_back((a == 5'h0C) ? IDCODE : m_regs[a]);
        cyc(1'b1, 1'b0, '0);
        while (done < READ_LAT + wc) begin
            if ($urandom_range(0, 3) == 0) begin
                cyc(1'b1, 1'b1, '0);
            end else begin
                cyc(1'b0, 1'b1, $urandom);
                done++;
            end
        end
        cyc(1'b1, 1'b0, '0);
    endtask

    task automatic do_toggle(input logic [4:0] a);
        cyc(1'b0, 1'b0, hdr1(2'b01, a, 11'd2));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, NOOP);
        cyc(1'b1, 1'b0, '0);
        if (m_synced) m_err = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // No sync: header and data are ignored.
        cyc(1'b0, 1'b0, 32'h30020001);
        cyc(1'b0, 1'b0, 32'h12345678);
        check_status();

        // Sync and WBSTAR write, with one cycle of mirror latency.
        do_sync();
        cyc(1'b0, 1'b0, NOOP);
        cyc(1'b0, 1'b0, 32'h30020001);
        cyc(1'b0, 1'b0, 32'h00400000);
        m_regs[16] = 32'h00400000;
        chk("wbstar_lat0", wbstar, 0);
        cyc(1'b1, 1'b0, '0);
        chk("wbstar_lat1", wbstar, 32'h00400000);
        check_status();

        // IDCODE read: valid on the fourth read cycle.
        cyc(1'b0, 1'b0, 32'h28018001);
        cyc(1'b0, 1'b0, NOOP);
        cyc(1'b0, 1'b0, NOOP);
        exp_q.push_back(IDCODE);
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < READ_LAT; i++) begin
            cyc(1'b0, 1'b1, '0);
            chk("rd_lat_wait", valid, 0);
        end
        cyc(1'b0, 1'b1, '0);
        chk("rd_lat_valid", valid, 1);
        chk("rd_idcode", dout, IDCODE);
        cyc(1'b1, 1'b0, '0);
        chk("rd_after_data", dout, 32'hFFFFFFFF);
        chk("rd_after_valid", valid, 0);
        check_status();

        // IPROG pulse then desync.
        cyc(1'b0, 1'b0, 32'h30008001);
        cyc(1'b0, 1'b0, 32'h0000000F);
        m_regs[4] = 32'h0000000F;
        m_synced = 1'b0;
        m_iprog++;
        chk("iprog_pulse", iprog, 1);
        chk("iprog_desync", synced, 0);
        cyc(1'b1, 1'b0, '0);
        chk("iprog_end", iprog, 0);
        check_status();

        // Type-2 header flags error; WBSTAR write still works.
        do_sync();
        cyc(1'b0, 1'b0, 32'h50000010);
        m_err = 1'b1;
        do_write(5'h10, 1, 32'hCAFEF00D);
        check_status();

        // Direction toggle mid-read.
        do_reset();
        do_sync();
        check_status();
        do_toggle(5'h10);
        check_status();

        // Reset between header and data.
        do_sync();
        do_write(5'h10, 1, 32'h11112222);
        check_status();
        cyc(1'b0, 1'b0, 32'h30020001);
        do_reset();
        cyc(1'b0, 1'b0, 32'hDEADBEEF);
        check_status();
        do_sync();
        do_write(5'h10, 1, 32'h33334444);
        check_status();

        for (int t = 0; t < 250; t++) begin
            int unsigned k;
            logic [4:0]  a;
            k = $urandom_range(0, 99);
            a = 5'($urandom_range(0, 31));
            if (k < 3) begin
                do_reset();
            end else if (!m_synced) begin
                if (k < 70) do_sync();
                else do_write(a, $urandom_range(1, 2), $urandom);
            end else if (k < 35) begin
                do_write(($urandom_range(0, 1) == 1) ? 5'h10 : a, $urandom_range(1, 3), $urandom);
            end else if (k < 65) begin
                do_read(($urandom_range(0, 3) == 0) ? 5'h0C : a, $urandom_range(1, 3));
            end else if (k < 70) begin
                do_write(5'h04, 1, 32'h0000000D);
            end else if (k < 73) begin
                do_write(5'h04, 1, 32'h0000000F);
            end else if (k < 78) begin
                cyc(1'b0, 1'b0, 32'h50000010);
                m_err = 1'b1;
            end else if (k < 82) begin
                do_toggle(a);
            end else begin
                cyc(1'b0, 1'b0, NOOP);
            end
            check_status();
        end

        repeat (4) cyc(1'b1, 1'b0, '0);
        chk("rdq_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icape2_responder.md
Name: icape2_responder

Overview:
- Cycle-level responder model of the 7-series ICAPE2 configuration port: the far end of our Wishbone-to-ICAP bridge.
- Consumes CSIB/RDWRB/I words and hunts for the sync word.
- Decodes type-1 packet headers and services register reads and writes against an internal 32-entry configuration register file.
- Drives O with read data and flags IPROG/DESYNC commands.
- Used in simulation benches and as a synthesizable stand-in on parts or FPGAs without ICAP access.

Parameters:
- IDCODE, 32'h0362D093, value returned from read-only register 5'h0C.
- READ_LAT, 3, cycles of active read (CSIB=0, RDWRB=1) before the first read word is presented; 1..7.

Ports:
- i_clk  in  1  port clock; one ICAP word per cycle when CSIB low.
- i_reset  in  1  asynchronous, active-high reset.
- i_csib  in  1  chip select, active low.
- i_rdwrb  in  1  1=read, 0=write; sampled only while i_csib=0.
- i_data  in  32  ICAP input word (I).
- o_data  out  32  ICAP output word (O).
- o_valid  out  1  o_data holds a read word this cycle.
- o_synced  out  1  sync word seen, no DESYNC since.
- o_iprog  out  1  one-cycle pulse on CMD=0x0F write.
- o_wbstar  out  32  current WBSTAR (reg 5'h10) contents.
- o_err  out  1  sticky: unsupported header or protocol violation.

Behaviour:
- Reset (async assert, sync release):
  - state=DESYNC; register file all zero except reg 5'h0C, which reads IDCODE.
  - o_data=32'hFFFFFFFF; o_valid=0; o_synced=0; o_iprog=0; o_wbstar=0; o_err=0.
- Word accepted: a rising edge of i_clk with i_csib=0. Any cycle with i_csib=1 is idle, and no state change occurs except as noted below.
- States:
  - DESYNC: write words are ignored until i_data==32'hAA995566 -> HDR, o_synced=1.
  - HDR: write words only.
    - 32'h20000000 (NOOP) and 32'hFFFFFFFF stay in HDR.
    - Type-1 header: [31:29]=001, op=[28:27], addr=[17:13], wc=[10:0].
      - op 00: no operation.
      - op 10 (write) with wc>0 -> WDATA, cnt=wc.
      - op 01 (read) with wc>0 -> RWAIT, cnt=wc.
      - wc=0 is a no-op.
    - Any other header: o_err=1, stay in HDR.
  - WDATA: each accepted write word is stored to reg[addr] (the last word wins); cnt decrements; cnt reaches 0 -> HDR. Writes to reg 5'h0C are discarded.
    - CMD side effects, applied on the data word when addr=5'h04:
      - 0x0D (DESYNC) -> DESYNC, o_synced=0, next cycle.
      - 0x0F (IPROG) -> o_iprog=1 for exactly one cycle, then DESYNC.
  - RWAIT: write-direction NOOPs are accepted and ignored. The first accepted word with i_rdwrb=1 starts lat=1 -> RLAT.
  - RLAT: each further read cycle increments lat. Once lat==READ_LAT -> RDATA.
  - RDATA: each read cycle presents o_data=reg[addr] with o_valid=1, registered (visible the cycle after sampling); cnt decrements; cnt reaches 0 -> HDR.
- Read pausing: i_csib=1 during RLAT/RDATA pauses; counters hold.
- Direction change while CS active: i_rdwrb toggling while i_csib=0 is a violation. o_err=1 and the block returns to HDR, except that a write of 0x0D to CMD still desyncs normally.
- Write during RLAT/RDATA with CS low: o_err=1, abort to HDR.
- o_data outside RDATA: 32'hFFFFFFFF; o_valid=0.
- o_wbstar mirrors reg 5'h10 with one cycle latency.
- Reset mid-packet: immediate return to the reset state; the register file is cleared.

Optional Feature:
- ICAPE2_RESP_BITSWAP_EN: when defined, i_data and o_data are bit-reversed within each byte at the ports, so the block presents the physical ICAPE2 pin ordering.
- When undefined, words are taken and returned in natural order.
- Decode logic is identical in both builds.

Decomposition:
- Package icape2_pkg:
  - sync word, NOOP, dummy word.
  - register address constants (CMD=5'h04, IDCODE=5'h0C, WBSTAR=5'h10).
  - command codes DESYNC=5'h0D, IPROG=5'h0F.
  - header field positions and opcode enum; state enum.
- Sub-module icape2_bitswap: per-byte bit reversal, instantiated twice under the macro.

Test Plan:
- No sync: write 0x30020001, 0x12345678 -> no register change, o_synced=0, o_wbstar=0.
- Sync and write: write 0xAA995566, 0x20000000, 0x30020001 (WBSTAR), 0x00400000 -> o_synced=1, o_wbstar=0x00400000 one cycle later.
- Read IDCODE: after sync, write 0x28018001, NOOP x2; CSIB high one cycle; RDWRB=1, CSIB low.
  - o_valid=1 with o_data=IDCODE on the 4th read cycle (READ_LAT=3).
  - After that, o_data=0xFFFFFFFF.
- IPROG: after sync, write 0x30008001, 0x0000000F -> single o_iprog pulse, o_synced=0 next cycle.
- Violations:
  - Type-2 header 0x50000010 -> o_err=1, and a subsequent WBSTAR write still succeeds.
  - Toggling RDWRB mid-read -> o_err=1.
- Reset mid-write (between header and data) -> all outputs at reset values, the data word is ignored, and sync is required again.
